// File: rtl/ahb_slave_memory.sv
// AHB subordinate memory model: word-organised RAM with byte-strobed writes,
// configurable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_slave_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int HPROT_WIDTH = 4
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [HPROT_WIDTH-1:0]  hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hreadyout,
  output logic                    hresp
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int BOFF = $clog2(NB);
  localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz);
    logic [ADDR_WIDTH-1:0] widx;
    logic [ADDR_WIDTH-1:0] amask;
    widx  = a >> BOFF;
    amask = (ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1);
    return (widx >= ADDR_WIDTH'(MEM_DEPTH)) || ((a & amask) != '0) || (int'(sz) > BOFF);
  endfunction

  function automatic logic [NB-1:0] lane_sel(input logic [BOFF-1:0] lo, input logic [2:0] sz);
    logic [NB-1:0] m;
    int off;
    int n;
    off = int'(lo);
    n   = 1 << sz;
    for (int b = 0; b < NB; b++) m[b] = (b >= off) && (b < off + n);
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] nw,
                                                  input logic [NB-1:0] be);
    logic [DATA_WIDTH-1:0] r;
    for (int b = 0; b < NB; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic            take;
  logic            accept, acc_err;
  logic [IDXW-1:0] acc_idx, rd_idx;
  logic            rd_is;

  logic [IDXW-1:0] idx_p1;
  logic [NB-1:0]   lanes_p1;
  logic            wr_p1;

  logic                  wr_en;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_word, rd_word, hrdata_d;

  logic unused;
  assign unused = ^{hburst, hprot, htrans[0]};

  assign accept  = hselx & hready & htrans[1];
  assign acc_err = addr_err(haddr, hsize);
  assign acc_idx = haddr[BOFF +: IDXW];

  assign wr_en   = (state == S_DATA) && wr_p1;
  assign wr_be   = hwstrb & lanes_p1;
  assign wr_word = merge(mem[idx_p1], hwdata, wr_be);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    take    = 1'b0;
    unique case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          take = 1'b1;
          if (acc_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_d = S_DATA;
        else           cnt_d   = cnt - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // A read accepted on the edge a write to the same word commits sees the merged word
  always_comb begin
    rd_idx   = take ? acc_idx : idx_p1;
    rd_is    = take ? ~hwrite : ~wr_p1;
    rd_word  = (wr_en && (idx_p1 == rd_idx)) ? wr_word : mem[rd_idx];
    hrdata_d = ((state_d == S_DATA) && rd_is) ? rd_word : '0;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hreadyout <= (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_ERR2);
      hresp     <= (state_d == S_ERR1) || (state_d == S_ERR2);
      hrdata    <= hrdata_d;
    end
  end

  // Address phase -> data phase boundary
  always_ff @(posedge hclk) begin
    if (take) begin
      idx_p1   <= acc_idx;
      lanes_p1 <= lane_sel(haddr[BOFF-1:0], hsize);
      wr_p1    <= hwrite;
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_en && !hreset) mem[idx_p1] <= wr_word;
  end

endmodule

// File: tb/tb_ahb_slave_memory.sv
// Bench for ahb_slave_memory: two instances (0 and 3 wait states) driven by a
// pipelined AHB master; a negedge monitor scores each data phase against a queue.
module tb_ahb_slave_memory;

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp;
    logic [3:0]  waits;
    logic [7:0]  id;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [1:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        block;
  logic [1:0]  hrdy;
  logic [1:0]  hro;
  logic [1:0]  hrsp;
  logic [31:0] hrd [2];

  exp_t sbq[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   xid = 0;
  logic mon_en = 1'b0;
  logic [1:0] pend = 2'b00;
  int   wcnt [2];

  always #5 hclk = ~hclk;

  assign hrdy = hro & ~{2{block}};

  ahb_slave_memory #(.WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hselx(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hwstrb(hwstrb), .hready(hrdy[0]), .hrdata(hrd[0]), .hreadyout(hro[0]), .hresp(hrsp[0])
  );

  ahb_slave_memory #(.WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .hselx(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hwstrb(hwstrb), .hready(hrdy[1]), .hrdata(hrd[1]), .hreadyout(hro[1]), .hresp(hrsp[1])
  );

  task automatic check(input string what, input int id, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (xfer %0d): got 0x%08h, expected 0x%08h", what, id, act, exp);
    end
  endtask

  // Monitor: outputs sampled mid-cycle; a data phase starts after a visible accept
  always @(negedge hclk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (hreset) begin
          if (pend[i]) begin
            pend[i] = 1'b0;
            if (sbq.size() > 0) void'(sbq.pop_front());
          end
        end else begin
          if (pend[i]) begin
            if (sbq.size() == 0) begin
              check("scoreboard_underflow", 0, 32'd1, 32'd0);
              pend[i] = 1'b0;
            end else begin
              e = sbq[0];
              if (!hro[i]) begin
                wcnt[i]++;
                check("wait_hresp", int'(e.id), 32'(hrsp[i]), 32'(e.resp));
                check("wait_hrdata", int'(e.id), hrd[i], 32'h0);
              end else begin
                check("wait_count", int'(e.id), 32'(wcnt[i]), 32'(e.waits));
                check("hresp", int'(e.id), 32'(hrsp[i]), 32'(e.resp));
                check("hrdata", int'(e.id), hrd[i], e.rdata);
                void'(sbq.pop_front());
                pend[i] = 1'b0;
              end
            end
          end else begin
            check($sformatf("idle_hreadyout_dut%0d", i), 0, 32'(hro[i]), 32'd1);
            check($sformatf("idle_hresp_dut%0d", i), 0, 32'(hrsp[i]), 32'd0);
            check($sformatf("idle_hrdata_dut%0d", i), 0, hrd[i], 32'h0);
          end
          if (hsel[i] && hrdy[i] && htrans[1]) begin
            pend[i] = 1'b1;
            wcnt[i] = 0;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(input int d, input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [3:0] st,
                       input int ew, input logic er, input logic [31:0] ed);
    exp_t t;
    int n;
    xid++;
    t.rdata = ed;
    t.resp  = er;
    t.waits = 4'(ew);
    t.id    = 8'(xid);
    sbq.push_back(t);
    hsel    = '0;
    hsel[d] = 1'b1;
    htrans  = 2'b10;
    haddr   = addr;
    hwrite  = wr;
    hsize   = sz;
    n = 0;
    @(negedge hclk);
    while (!hrdy[d] && n < 40) begin
      n++;
      @(negedge hclk);
    end
    if (!hrdy[d]) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout (xfer %0d): hready stuck low, expected high", xid);
      void'(sbq.pop_back());
    end
    @(posedge hclk);
    #1;
    hwdata = wd;
    hwstrb = st;
    htrans = 2'b00;
    hsel   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    hreset = 1'b1; hsel = '0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hburst = '0; hprot = '0; hwdata = '0; hwstrb = '0; block = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // zero wait states: write/read, byte forwarding, halfword lanes, errors
    issue(0, 1, 32'h10,  2, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0);
    issue(0, 0, 32'h10,  2, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF);
    issue(0, 1, 32'h20,  2, 32'h11223344, 4'hF, 0, 0, 32'h0);
    issue(0, 1, 32'h21,  0, 32'h0000AA00, 4'b0010, 0, 0, 32'h0);
    issue(0, 0, 32'h20,  2, 32'h0,        4'h0, 0, 0, 32'h1122AA44);
    issue(0, 0, 32'h20,  2, 32'h0,        4'h0, 0, 0, 32'h1122AA44);
    issue(0, 1, 32'h00,  2, 32'h01020304, 4'hF, 0, 0, 32'h0);
    issue(0, 1, 32'h02,  2, 32'hFFFFFFFF, 4'hF, 1, 1, 32'h0);
    issue(0, 0, 32'h00,  2, 32'h0,        4'h0, 0, 0, 32'h01020304);
    issue(0, 0, 32'h400, 2, 32'h0,        4'h0, 1, 1, 32'h0);
    issue(0, 1, 32'h12,  1, 32'h5A5A5A5A, 4'hF, 0, 0, 32'h0);
    issue(0, 0, 32'h10,  2, 32'h0,        4'h0, 0, 0, 32'h5A5ABEEF);
    issue(0, 0, 32'h08,  3, 32'h0,        4'h0, 1, 1, 32'h0);
    issue(0, 1, 32'h3FC, 2, 32'hA5A5A5A5, 4'hF, 0, 0, 32'h0);
    issue(0, 0, 32'h3FC, 2, 32'h0,        4'h0, 0, 0, 32'hA5A5A5A5);
    idle(3);

    // IDLE and BUSY with select, then NONSEQ held off by another subordinate
    hsel = 2'b01; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    htrans = 2'b00; hwdata = 32'h55555555; hwstrb = 4'hF;
    idle(1);
    htrans = 2'b01;
    idle(1);
    block = 1'b1;
    htrans = 2'b10;
    idle(2);
    block = 1'b0;
    htrans = 2'b00;
    hsel = '0;
    idle(2);
    issue(0, 0, 32'h10, 2, 32'h0, 4'h0, 0, 0, 32'h5A5ABEEF);
    idle(3);

    // three wait states, error timing, reset in the second wait cycle of a write
    issue(1, 1, 32'h40,  2, 32'hCAFEF00D, 4'hF, 3, 0, 32'h0);
    issue(1, 0, 32'h40,  2, 32'h0,        4'h0, 3, 0, 32'hCAFEF00D);
    issue(1, 0, 32'h400, 2, 32'h0,        4'h0, 1, 1, 32'h0);
    issue(1, 1, 32'h40,  2, 32'h12345678, 4'hF, 3, 0, 32'h0);
    idle(1);
    hreset = 1'b1;
    idle(1);
    hreset = 1'b0;
    idle(2);
    issue(1, 0, 32'h40,  2, 32'h0,        4'h0, 3, 0, 32'hCAFEF00D);
    idle(6);

    check("scoreboard_drained", 0, 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_slave_memory.md
# ahb_slave_memory

AHB subordinate memory model that sits directly downstream of the AHB interconnect. It consumes the address/control and write-data signals that the interconnect drives towards the selected subordinate, and returns `hrdata`, `hreadyout` and `hresp`. It holds a word-organised internal RAM, supports byte-strobed writes and a configurable number of wait states, and returns a two-cycle ERROR response for illegal accesses. The AHB VIP uses it as the reference subordinate for master-side tests.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data bus width; one of 32 or 64
- `MEM_DEPTH`, 256, number of `DATA_WIDTH` words
- `WAIT_STATES`, 0, number of `hreadyout`-low cycles inserted before each OKAY data phase; range 0..15

Ports:
- `hclk` in 1 — clock; all logic on the rising edge
- `hreset` in 1 — reset; synchronous, active-high
- `hselx` in 1 — subordinate select
- `haddr` in ADDR_WIDTH — byte address
- `htrans` in 2 — IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- `hwrite` in 1 — 1 = write
- `hsize` in 3 — transfer size, bytes = 2^hsize
- `hburst` in 3 — accepted but not decoded
- `hprot` in HPROT_WIDTH — accepted but not decoded
- `hwdata` in DATA_WIDTH — write data, data phase
- `hwstrb` in DATA_WIDTH/8 — write byte strobes, data phase
- `hready` in 1 — bus-wide ready from the interconnect
- `hrdata` out DATA_WIDTH — read data
- `hreadyout` out 1 — subordinate ready
- `hresp` out 1 — 0 = OKAY, 1 = ERROR

## Operation

Address-phase accept:
- An address phase is accepted on a rising edge where `hselx & hready & htrans[1]`.
- On accept, register the address, `hwrite`, `hsize` and an error flag.
- IDLE and BUSY transfers, and unselected cycles, get a zero-wait OKAY.

Error conditions, evaluated at accept:
- Word index `haddr >> log2(DATA_WIDTH/8)` is ≥ MEM_DEPTH.
- `haddr` is not aligned to 2^hsize.
- 2^hsize > DATA_WIDTH/8.

States:
- IDLE
  - Drives `hreadyout`=1, `hresp`=0.
  - Accept with error → ERR1.
  - Accept without error and WAIT_STATES>0 → WAIT, with the counter loaded to WAIT_STATES-1.
  - Accept without error and WAIT_STATES=0 → DATA.
- WAIT
  - Drives `hreadyout`=0, `hresp`=0.
  - Counter decrements each cycle; at 0 → DATA.
- DATA (completing cycle)
  - Drives `hreadyout`=1, `hresp`=0.
  - A write commits on this edge.
  - A new accept on this edge follows the same rules as in IDLE (back-to-back transfers); otherwise → IDLE.
- ERR1
  - Drives `hreadyout`=0, `hresp`=1.
  - → ERR2 unconditionally; new address-phase inputs are ignored.
- ERR2
  - Drives `hreadyout`=1, `hresp`=1.
  - A new accept on this edge is handled as in IDLE; otherwise → IDLE.

Write and read data rules:
- Written byte lanes = `hwstrb` AND the lanes selected by the registered `hsize`/address.
- Errored writes never modify memory.
- `hrdata` carries the read word only during the DATA cycle of a read; it is 0 at all other times.
- Read-after-write forwarding: a read whose address phase coincides with the committing DATA cycle of a write to the same word returns the merged, new data.

Reset:
- Memory contents are not reset.
- `hreset` asserted in any state: next state IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0, wait counter 0.
- Any pending write is dropped.

## Timing
- Reset values: `hreadyout`=1, `hresp`=0, `hrdata`=0.
- OKAY latency: data phase completes WAIT_STATES+1 cycles after the accepting edge.
  - With WAIT_STATES=0, read data is valid in the cycle immediately after the address phase.
- ERROR: exactly two cycles — (hreadyout=0, hresp=1) then (hreadyout=1, hresp=1).
- `hready` low from another subordinate blocks accept; state and outputs are unchanged.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Write then read, WAIT_STATES=0, DATA_WIDTH=32: NONSEQ write to 0x10 with `hwdata`=0xDEADBEEF and `hwstrb`=4'hF, then a read of 0x10 → `hrdata`=0xDEADBEEF one cycle after the read address phase, `hresp`=0.
- Back-to-back forwarding: word 0x20 preloaded with 0x11223344; byte write of 0xAA to 0x21 (hsize=0, `hwstrb`=4'b0010) with a read of 0x20 in the immediately following address phase → read returns 0x1122AA44.
- Wait states, WAIT_STATES=3: read of a valid address → `hreadyout` low for exactly 3 cycles, then high with data.
- Errors: read at address 4*MEM_DEPTH → `hreadyout`/`hresp` sequence 0/1 then 1/1. Misaligned word write to 0x02 → same sequence, and memory unchanged on readback.
- IDLE/BUSY and hready: `htrans`=IDLE or BUSY with `hselx`=1 → `hreadyout`=1, `hresp`=0, no memory access. NONSEQ with `hready`=0 → not accepted.
- Reset mid-transfer: WAIT_STATES=3, `hreset` asserted in the second WAIT cycle of a write → next cycle `hreadyout`=1, `hresp`=0, `hrdata`=0; a later read of that address returns the old data.
